// File: rtl/param_loader.sv
// Loads 13 configuration nibbles and a 256-nibble string from switch/rotary-encoder entry,
// then waits in READY for a PB1 press to pulse start downstream.
module param_loader #(
  parameter int unsigned CFG_NIBBLES = 13,
  parameter int unsigned STR_LEN     = 256,
  localparam int unsigned AW         = $clog2(STR_LEN),
  localparam int unsigned CW         = $clog2(CFG_NIBBLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    Y,
  input  logic          rot_a,
  input  logic          rot_b,
  input  logic          PB1,
  output logic [11:0]   eci,
  output logic [3:0]    probe_blocks,
  output logic [7:0]    crf_blocks0,
  output logic [7:0]    crf_blocks1,
  output logic [7:0]    crf_blocks2,
  output logic [3:0]    exp0,
  output logic [3:0]    exp1,
  output logic [3:0]    exp2,
  output logic          str_we,
  output logic [AW-1:0] str_addr,
  output logic [3:0]    str_data,
  output logic          start,
  output logic [7:0]    led
);

  typedef enum logic [1:0] {StCfg = 2'b00, StStr = 2'b01, StReady = 2'b10} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;

  logic       r_a_s1, r_a_s2, r_b_s1, r_b_s2, r_ab_q;
  logic [3:0] r_y_s1, r_y_s2;
  logic       r_pb_tog, r_pb_s1, r_pb_s2, r_pb_s3;
  logic       w_event, w_pb_req, w_cfg_ld, w_str_wr, w_start;

  logic [3:0]    r_cfg [CFG_NIBBLES];
  logic [3:0]    r_last;
  logic          r_str_we, r_start;
  logic [AW-1:0] r_str_addr;
  logic [3:0]    r_str_data;

  // A PB1 press toggles this flop so even a sub-cycle pulse survives into the clk domain.
  always_ff @(posedge PB1 or negedge rst_n) begin
    if (!rst_n) r_pb_tog <= 1'b0;
    else        r_pb_tog <= ~r_pb_tog;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_s1  <= 1'b0;
      r_a_s2  <= 1'b0;
      r_b_s1  <= 1'b0;
      r_b_s2  <= 1'b0;
      r_ab_q  <= 1'b0;
      r_y_s1  <= 4'h0;
      r_y_s2  <= 4'h0;
      r_pb_s1 <= 1'b0;
      r_pb_s2 <= 1'b0;
      r_pb_s3 <= 1'b0;
    end else begin
      r_a_s1  <= rot_a;
      r_a_s2  <= r_a_s1;
      r_b_s1  <= rot_b;
      r_b_s2  <= r_b_s1;
      r_ab_q  <= r_a_s2 & r_b_s2;
      r_y_s1  <= Y;
      r_y_s2  <= r_y_s1;
      r_pb_s1 <= r_pb_tog;
      r_pb_s2 <= r_pb_s1;
      r_pb_s3 <= r_pb_s2;
    end
  end

  assign w_event  = r_a_s2 & r_b_s2 & ~r_ab_q;
  // Request is consumed every cycle; outside READY it is simply dropped.
  assign w_pb_req = r_pb_s2 ^ r_pb_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StCfg;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cfg_ld    = 1'b0;
    w_str_wr    = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      StCfg: begin
        if (w_event) begin
          w_cfg_ld = 1'b1;
          if (r_cnt == AW'(CFG_NIBBLES - 1)) begin
            w_state_nxt = StStr;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      StStr: begin
        if (w_event) begin
          w_str_wr  = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == AW'(STR_LEN - 1)) w_state_nxt = StReady;
        end
      end
      StReady: begin
        if (w_pb_req) begin
          w_start     = 1'b1;
          w_state_nxt = StCfg;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = StCfg;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CFG_NIBBLES); i++) r_cfg[i] <= 4'h0;
      r_last     <= 4'h0;
      r_str_we   <= 1'b0;
      r_start    <= 1'b0;
      r_str_addr <= '0;
      r_str_data <= 4'h0;
    end else begin
      r_str_we <= w_str_wr;
      r_start  <= w_start;
      if (w_cfg_ld) r_cfg[r_cnt[CW-1:0]] <= r_y_s2;
      if (w_cfg_ld || w_str_wr) r_last <= r_y_s2;
      if (w_str_wr) begin
        r_str_addr <= r_cnt;
        r_str_data <= r_y_s2;
      end
    end
  end

  assign eci          = {r_cfg[0], r_cfg[1], r_cfg[2]};
  assign probe_blocks = r_cfg[3];
  assign crf_blocks0  = {r_cfg[4], r_cfg[5]};
  assign exp0         = r_cfg[6];
  assign crf_blocks1  = {r_cfg[7], r_cfg[8]};
  assign exp1         = r_cfg[9];
  assign crf_blocks2  = {r_cfg[10], r_cfg[11]};
  assign exp2         = r_cfg[12];
  assign str_we       = r_str_we;
  assign str_addr     = r_str_addr;
  assign str_data     = r_str_data;
  assign start        = r_start;
  assign led          = {r_state, 2'b00, r_last};

endmodule

// File: tb/tb_param_loader.sv
// Scoreboard bench for param_loader: stimulus pushes expected writes/starts, a negedge
// monitor pops and compares them; field values are checked against hand-computed constants.
module tb_param_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Y = 4'h0;
  logic       rot_a = 1'b0, rot_b = 1'b0, PB1 = 1'b0;
  logic [11:0] eci;
  logic [3:0]  probe_blocks, exp0, exp1, exp2, str_data;
  logic [7:0]  crf_blocks0, crf_blocks1, crf_blocks2, str_addr, led;
  logic        str_we, start;

  param_loader dut (
    .clk(clk), .rst_n(rst_n), .Y(Y), .rot_a(rot_a), .rot_b(rot_b), .PB1(PB1),
    .eci(eci), .probe_blocks(probe_blocks), .crf_blocks0(crf_blocks0),
    .crf_blocks1(crf_blocks1), .crf_blocks2(crf_blocks2), .exp0(exp0), .exp1(exp1),
    .exp2(exp2), .str_we(str_we), .str_addr(str_addr), .str_data(str_data),
    .start(start), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_start; logic [7:0] addr; logic [3:0] data;} exp_t;
  exp_t q[$];

  int n_checks = 0, n_errors = 0, n_we = 0, n_start = 0;

  logic [3:0] cfg_a [13] = '{4'h0, 4'h0, 4'h8, 4'h2, 4'h1, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2,
                             4'h0, 4'h0, 4'h0};
  logic [3:0] cfg_b [13] = '{4'hA, 4'h3, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                             4'hB, 4'hC, 4'hD};
  logic [3:0] cfg_c [13] = '{4'h7, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                             4'hA, 4'hB, 4'hC};

  function automatic logic [63:0] fields();
    return {12'h0, eci, probe_blocks, crf_blocks0, exp0, crf_blocks1, exp1, crf_blocks2, exp2};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive one encoder detent: both contacts high, then both low.
  task automatic entry(input logic [3:0] y);
    @(posedge clk); #2 Y = y;
    @(posedge clk); #2 rot_a = 1'b1; rot_b = 1'b1;
    repeat (4) @(posedge clk);
    #2 rot_a = 1'b0; rot_b = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic pb_pulse();
    @(posedge clk); #3 PB1 = 1'b1;
    #2 PB1 = 1'b0;
  endtask

  task automatic wait_start(input int target, input string nm);
    for (int i = 0; i < 4 && n_start < target; i++) begin
      @(posedge clk); #1;
    end
    chk(nm, 64'(n_start), 64'(target));
  endtask

  task automatic str_write(input logic [7:0] a, input logic [3:0] d);
    q.push_back('{is_start: 1'b0, addr: a, data: d});
    entry(d);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (str_we) n_we++;
      if (start)  n_start++;
      if (str_we && start) begin
        n_checks++; n_errors++;
        $display("FAIL we_start_overlap actual=both required=at_most_one");
      end else if (str_we || start) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_output actual=we%0b/start%0b addr=%h data=%h required=none",
                   str_we, start, str_addr, str_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_start != start || (!e.is_start && (str_addr !== e.addr ||
              str_data !== e.data))) begin
            n_errors++;
            $display("FAIL scoreboard actual=start%0b addr=%h data=%h required=start%0b addr=%h data=%h",
                     start, str_addr, str_data, e.is_start, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fields", fields(), 64'h0);
    chk("reset_str", {str_we, start, str_addr, str_data}, 64'h0);
    chk("reset_led", 64'(led), 64'h0);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 13; k++) entry(cfg_a[k]);
    chk("cfg_a_eci", 64'(eci), 64'h008);
    chk("cfg_a_probe", 64'(probe_blocks), 64'h2);
    chk("cfg_a_set0", {crf_blocks0, exp0}, 64'h101);
    chk("cfg_a_set1", {crf_blocks1, exp1}, 64'h122);
    chk("cfg_a_set2", {crf_blocks2, exp2}, 64'h000);
    chk("cfg_a_led", 64'(led[7:6]), 64'h1);

    for (int i = 0; i < 256; i++) str_write(8'(i), 4'hB);
    repeat (2) @(posedge clk); #1;
    chk("str_count", 64'(n_we), 64'd256);
    chk("str_ready_led", 64'(led), 64'h8B);

    for (int i = 0; i < 3; i++) entry(4'hF);
    chk("ready_fields_hold", fields(), 64'h0082_1011_2200_0);
    chk("ready_no_write", 64'(n_we), 64'd256);
    chk("ready_led_hold", 64'(led), 64'h8B);

    q.push_back('{is_start: 1'b1, addr: 8'h0, data: 4'h0});
    pb_pulse();
    wait_start(1, "start_pulse");
    @(posedge clk); #1;
    chk("start_to_cfg", 64'(led[7:6]), 64'h0);

    @(posedge clk); #2 Y = 4'hA;
    @(posedge clk); #2 rot_a = 1'b1; rot_b = 1'b1;
    repeat (20) @(posedge clk);
    #2 rot_a = 1'b0; rot_b = 1'b0;
    repeat (3) @(posedge clk);
    #2 Y = 4'h5;
    @(posedge clk); #2 rot_a = 1'b1;
    repeat (6) @(posedge clk);
    #2 rot_a = 1'b0;
    repeat (3) @(posedge clk);
    entry(4'h3);
    chk("hold_one_event", 64'(eci), 64'hA38);
    chk("hold_led", 64'(led), 64'h03);

    for (int k = 2; k < 13; k++) entry(cfg_b[k]);
    chk("cfg_b_fields", fields(), 64'h0A31_4567_89AB_CD);
    chk("cfg_b_led", 64'(led[7:6]), 64'h1);

    for (int i = 0; i < 100; i++) begin
      str_write(8'(i), 4'(i));
      if (i == 50) begin
        pb_pulse();
        repeat (6) @(posedge clk); #1;
        chk("pb_in_str_no_start", 64'(n_start), 64'd1);
        chk("pb_in_str_state", 64'(led[7:6]), 64'h1);
      end
    end
    repeat (2) @(posedge clk); #1;
    chk("str100_drained", 64'(q.size()), 64'd0);
    chk("str100_count", 64'(n_we), 64'd356);

    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midload_reset_fields", fields(), 64'h0);
    chk("midload_reset_out", {str_we, start, str_addr, str_data, led}, 64'h0);
    #3 rst_n = 1'b1;

    entry(4'h7);
    chk("restart_nibble0", fields(), 64'h0700_0000_0000_00);
    for (int k = 1; k < 13; k++) entry(cfg_c[k]);
    chk("cfg_c_fields", fields(), 64'h0712_3456_789A_BC);
    for (int i = 0; i < 256; i++) str_write(8'(i), 4'(i) ^ 4'h5);
    repeat (2) @(posedge clk); #1;
    chk("second_ready_led", 64'(led), 64'h8A);

    q.push_back('{is_start: 1'b1, addr: 8'h0, data: 4'h0});
    @(posedge clk); #2 Y = 4'hF;
    @(posedge clk); #2 rot_a = 1'b1; rot_b = 1'b1; PB1 = 1'b1;
    #2 PB1 = 1'b0;
    wait_start(2, "coincident_start");
    #2 rot_a = 1'b0; rot_b = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("coincident_no_write", 64'(n_we), 64'd612);
    chk("coincident_fields", fields(), 64'h0712_3456_789A_BC);
    chk("coincident_led", 64'(led), 64'h0A);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 Parameter: CFG_NIBBLES, 13, number of configuration nibbles loaded before the input string.
REQ-002 Parameter: STR_LEN, 256, number of input-string nibbles; the address width is log2(STR_LEN) = 8.
REQ-003 Port: clk  in  1  single system clock; all state changes on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: Y  in  4  data nibble from the switches, asynchronous to clk.
REQ-006 Port: rot_a, rot_b  in  1 each  rotary-encoder contacts, asynchronous; one entry event = both high after both low.
REQ-007 Port: PB1  in  1  start pushbutton, asynchronous; pulse may be shorter than one clk period.
REQ-008 Port: eci  out  12  ECI value; first captured nibble is most significant.
REQ-009 Port: probe_blocks  out  4  sender probe block count.
REQ-010 Port: crf_blocks0, crf_blocks1, crf_blocks2  out  8 each  CRF block counts, MS nibble first.
REQ-011 Port: exp0, exp1, exp2  out  4 each  experiment selectors.
REQ-012 Port: str_we  out  1  one-cycle string write strobe.
REQ-013 Port: str_addr  out  8  string write address.
REQ-014 Port: str_data  out  4  string write nibble.
REQ-015 Port: start  out  1  one-cycle pulse to the downstream environment/engine.
REQ-016 Port: led  out  8  status: led[7:6] = state code (CFG=00, STR=01, READY=10), led[5:4] = 0, led[3:0] = last captured nibble.

Function
REQ-017 Each of rot_a, rot_b and Y shall pass through a 2-flop synchronizer; Y shall use the same depth so data aligns with the event.
REQ-018 An entry event shall be the single cycle in which the synchronized (rot_a AND rot_b) is 1 and its previous-cycle value was 0; holding both high yields exactly one event.
REQ-019 On an event, the synchronized Y of that cycle shall be captured; the register update or str_we shall occur in the next cycle (3 clk after the async rising edge, ±1 for metastability).
REQ-020 FSM states shall be CFG, STR and READY; the reset state is CFG with nibble counter 0.
REQ-021 In CFG, nibble k (0..12) shall load fields in this order: eci[11:8], eci[7:4], eci[3:0], probe_blocks, crf_blocks0[7:4], crf_blocks0[3:0], exp0, crf_blocks1[7:4], crf_blocks1[3:0], exp1, crf_blocks2[7:4], crf_blocks2[3:0], exp2.
REQ-022 After nibble 12, the FSM shall go to STR with the counter cleared.
REQ-023 In STR, each event shall assert str_we for one cycle with str_addr = counter and str_data = the captured nibble, then increment the counter.
REQ-024 After address 255 is written, the FSM shall go to READY and the counter shall wrap to 0.
REQ-025 In READY, entry events shall be ignored; no register changes and no str_we.
REQ-026 PB1 shall set a capture flag asynchronously on its rising edge; the flag shall be synchronized (2 flops) and cleared synchronously once consumed.
REQ-027 A synchronized PB1 flag in CFG or STR shall be discarded and cleared, with no effect.
REQ-028 A synchronized PB1 flag in READY shall assert start for exactly one cycle and return the FSM to CFG with counter 0.
REQ-029 Configuration outputs shall hold their values until overwritten by a later load.
REQ-030 If an entry event and the PB1 flag are both seen in the same READY cycle, start shall win and the event shall be dropped.
REQ-031 str_we and start shall never both be asserted in the same cycle.

Reset
REQ-032 While rst_n = 0, regardless of clk: all config outputs = 0, str_we = 0, str_addr = 0, str_data = 0, start = 0, led = 0, FSM = CFG, counter = 0, synchronizers and PB1 flag = 0.
REQ-033 Reset asserted mid-load shall abandon the load; after release, loading restarts at nibble 0 of CFG.

Verification
REQ-034 Enter 13 events with Y = 0,0,8,2,1,0,1,1,2,2,0,0,0 -> eci = 12'h008, probe_blocks = 2, crf_blocks0 = 8'h10, exp0 = 1, crf_blocks1 = 8'h12, exp1 = 2, crf_blocks2 = 8'h00, exp2 = 0, led[7:6] = 01.
REQ-035 Then 256 events with Y = 4'hB -> exactly 256 str_we pulses, addresses 0..255 in order, data B, final led[7:6] = 10.
REQ-036 Hold rot_a = rot_b = 1 for 20 cycles -> exactly one event; rot_a alone high -> no event.
REQ-037 In READY, a 2 ns PB1 pulse between clk edges -> one start pulse within 4 cycles, FSM = CFG; a PB1 pulse during STR -> no start.
REQ-038 Events in READY with Y = F -> no str_we and outputs unchanged; rst_n low after 100 string writes -> all outputs 0 immediately, and the next event loads eci[11:8].
REQ-039 Event coincident with PB1 in READY -> start = 1, no field or string write.
